vga_pixel_output_stage: RTL

//  Downstream of the objects priority mux. Generates the 640x480@60 VGA raster
//  (pixelX/pixelY/startOfFrame) consumed by all drawing objects. Samples the
//  mux's 8-bit RRRGGGBB result and expands it to 8-bit-per-channel DAC values.

---
 rtl/vga_pixel_output_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_pixel_output_stage.sv
// vga_pixel_output_stage
// ----------------------------------------------------------------------------
// Final stage of the video path. It runs the VGA raster counters that every
// drawing object reads. It registers the priority-mux colour and expands it to
// 8-bit DAC channels. It delays the per-coordinate active/hsync/vsync flags so
// that they leave the block on the same tick as the colour for that coordinate.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   pixel_en      in   pixel tick qualifier (one clk wide)
//   rgb_in        in   [7:0]  mux colour {R[2:0],G[2:0],B[1:0]}
//   pixelX        out  [10:0] current horizontal count
//   pixelY        out  [10:0] current vertical count
//   startOfFrame  out  one-clk pulse when the raster wraps to (0,0)
//   red/green/blue out [7:0]  DAC channel values
//   hsync, vsync  out  sync outputs, asserted level = SYNC_POL
//   blank_n       out  1 = active video at the DAC output
//
// Pixel tick: there is no handshake. pixel_en is a pure enable. Every register
// in the block advances on a clk edge where pixel_en=1 and holds otherwise, so
// stalling pixel_en for any length of time loses and repeats nothing.
// startOfFrame is the exception: it is a pulse and returns to 0 on the next clk.
// ----------------------------------------------------------------------------
module vga_pixel_output_stage #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DEPTH = 2,     // 1..4 ticks, coordinate issue to DAC
   parameter bit SYNC_POL   = 1'b0   // asserted sync level
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixel_en,
   input  logic [7:0]  rgb_in,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Flags for the coordinate the counters show now, packed as {active, hs, vs}.
   // All-zero means "blank, no sync", which is also the reset contents of the
   // delay line.
   logic       raw_active;
   logic       raw_hs;
   logic       raw_vs;
   logic [2:0] raw_flags;
   logic [2:0] tap;

   assign raw_active = (pixelX < H_ACT) && (pixelY < V_ACT);
   assign raw_hs     = (pixelX >= HS_FIRST) && (pixelX <= HS_LAST);
   assign raw_vs     = (pixelY >= VS_FIRST) && (pixelY <= VS_LAST);
   assign raw_flags  = {raw_active, raw_hs, raw_vs};

   // Raster counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixelX       <= 11'd0;
         pixelY       <= 11'd0;
         startOfFrame <= 1'b0;
      end else begin
         startOfFrame <= 1'b0;
         if (pixel_en) begin
            if (pixelX == H_LAST) begin
               pixelX <= 11'd0;
               if (pixelY == V_LAST) begin
                  pixelY       <= 11'd0;
                  startOfFrame <= 1'b1;
               end else begin
                  pixelY <= pixelY + 11'd1;
               end
            end else begin
               pixelX <= pixelX + 11'd1;
            end
         end
      end
   end

   // The flag delay line is PIPE_DEPTH-1 stages long. The output register adds
   // the last tick, so the total latency is PIPE_DEPTH ticks. At depth 1 the
   // output register takes the raw flags directly.
   generate
      if (PIPE_DEPTH <= 1) begin : g_no_delay
         assign tap = raw_flags;
      end else begin : g_delay
         logic [2:0] stage [PIPE_DEPTH-1];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < PIPE_DEPTH - 1; i++) stage[i] <= 3'b000;
            end else if (pixel_en) begin
               stage[0] <= raw_flags;
               for (int i = 1; i < PIPE_DEPTH - 1; i++) stage[i] <= stage[i-1];
            end
         end

         assign tap = stage[PIPE_DEPTH-2];
      end
   endgenerate

   // Output register. The colour is sampled on the same tick that the delayed
   // flags arrive. The upstream mux latency is absorbed by the delay line
   // rather than by a colour pipeline.
   // Channel expansion uses bit replication, so full scale maps to 0xFF.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red     <= 8'h00;
         green   <= 8'h00;
         blue    <= 8'h00;
         blank_n <= 1'b0;
         hsync   <= ~SYNC_POL;
         vsync   <= ~SYNC_POL;
      end else if (pixel_en) begin
         blank_n <= tap[2];
         hsync   <= tap[1] ? SYNC_POL : ~SYNC_POL;
         vsync   <= tap[0] ? SYNC_POL : ~SYNC_POL;
         if (tap[2]) begin
            red   <= {rgb_in[7:5], rgb_in[7:5], rgb_in[7:6]};
            green <= {rgb_in[4:2], rgb_in[4:2], rgb_in[4:3]};
            blue  <= {4{rgb_in[1:0]}};
         end else begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
         end
      end
   end

endmodule
